src_control_unit: RTL
=====================

// Module: src_control_unit
// PURPOSE
//  Hardwired Moore sequencer for the Mini SRC datapath: drives bus-select, register-load, ALU-op and
//  memory strobes for fetch and execute of a core instruction subset. Sits beside the datapath; the
//  32-bit registers (PC, IR, MAR, MDR, Y, Z, R0-R15) load only when this block raises their enables.
//  Memory accesses use a mem_rdy wait handshake guarded by a timeout counter.
// PARAMETERS
//  WAIT_LIMIT  16  max cycles a read/write may wait for mem_rdy before entering FAULT (>=1)
//  CNT_W       5   width of wait counter; must satisfy 2**CNT_W > WAIT_LIMIT
// PORTS
//  clk       in   1   clock; all state changes on rising edge
//  clr       in   1   reset, asynchronous, active-high
//  ir        in   32  current IR contents; opcode = ir[31:27]
//  mem_rdy   in   1   memory completes the current mem_rd/mem_wr this cycle
//  pc_out, pc_inc, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in, zlo_out  out 1 each  datapath strobes
//  mdr_rd    out  1   MDR input mux selects memory data (0 = bus)
//  gra, grb, grc  out 1 each  select Ra/Rb/Rc field of IR for register-file access
//  r_in, r_out, ba_out, c_out  out 1 each  regfile load / drive / base-or-zero drive / sign-ext C drive
//  alu_op    out  5   ALU operation code; equals opcode for ALU classes, 5'b00011 (ADD) for address calc
//  mem_rd, mem_wr  out 1 each  memory request, held until mem_rdy
//  run       out  1   high while sequencing; low in HALT and FAULT
//  fault     out  1   high in FAULT (memory timeout)
//  illegal   out  1   one-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  - Reset: state=F0, wait_cnt=0; all strobes 0, alu_op=0, run=1, fault=0, illegal=0. clr mid-operation
//    aborts any access immediately (mem_rd/mem_wr drop asynchronously).
//  - Outputs are pure functions of state (Moore), except ir-decoded fields, which are sampled in
//    DECODE; IR is stable after F2.
//  - Fetch: F0 pc_out,mar_in,pc_inc -> F1 mem_rd,mdr_rd; mdr_in only in the cycle mem_rdy=1, then F2
//    -> F2 mdr_out,ir_in -> DECODE (no strobes).
//  - DECODE by opcode: 00011-01011,01111,10000 ALU_R; 01100-01110 ALU_I; 00000 LD; 00001 LDI; 00010 ST;
//    11010 NOP -> F0; 11011 HALT; all others: illegal pulse, -> F0.
//  - ALU_R: E3 grb,r_out,y_in -> E4 grc,r_out,alu_op=op,z_in -> E5 zlo_out,gra,r_in -> F0.
//  - ALU_I: E3 grb,r_out,y_in -> E4 c_out,alu_op=op,z_in -> E5 zlo_out,gra,r_in -> F0.
//  - LD/LDI/ST: E3 grb,ba_out,y_in -> E4 c_out,alu_op=ADD,z_in -> E5: LDI zlo_out,gra,r_in -> F0;
//    LD/ST zlo_out,mar_in -> E6.
//  - LD: E6 mem_rd,mdr_rd, mdr_in on mem_rdy -> E7 mdr_out,gra,r_in -> F0.
//  - ST: E6 gra,r_out,mdr_in -> E7 mem_wr until mem_rdy -> F0.
//  - Wait states (F1, LD E6, ST E7): wait_cnt increments each cycle mem_rdy=0; cleared on state exit.
//    mem_rdy=1 on the same cycle the count reaches WAIT_LIMIT counts as success.
//    wait_cnt==WAIT_LIMIT with mem_rdy=0 -> FAULT. mem_rdy outside wait states is ignored.
//  - HALT and FAULT are absorbing: all strobes 0, run=0; exit only via clr.
//  - Latency with zero-wait memory: NOP 4 cycles, ALU 7, LDI 7, LD 9, ST 9.
// STRUCTURE
//  - Shared package src_pkg: opcode localparams (OP_LD..OP_HALT), ALU_ADD, state enum encoding.
//  - One sub-module: src_wait_timer (counter + timeout compare, CNT_W/WAIT_LIMIT params).
//  - FSM next-state and output decode stay in this module.
// TESTING
//  - clr pulse mid-E4 of ADD -> next cycle state F0, all strobes 0, run=1; register enables never glitch high.
//  - ir=32'h18A30000 (add), mem_rdy=1 -> F0..E5 in 7 cycles; E4 alu_op=5'b00011,grc,r_out,z_in; E5 gra,r_in.
//  - ld with mem_rdy delayed 3 cycles in F1 and in E6 -> mdr_in asserted exactly once per access; total 15 cycles.
//  - st, ir=32'h10800004 -> E6 gra,r_out,mdr_in; E7 mem_wr held until mem_rdy; no r_in in any cycle.
//  - WAIT_LIMIT=4, mem_rdy stuck 0 in F1 -> FAULT after 4 wait cycles; fault=1, run=0, mem_rd=0, held until clr.
//  - opcode 11111 -> illegal=1 for one DECODE cycle, then F0; opcode 11011 -> run=0, all strobes 0 for 20 cycles.

Source files
------------

// File: rtl/src_pkg.sv
// Shared opcode map, state/class encodings and the opcode classifier for the
// Mini SRC hardwired control unit.
package src_pkg;

  localparam logic [4:0] OP_LD        = 5'b00000;
  localparam logic [4:0] OP_LDI       = 5'b00001;
  localparam logic [4:0] OP_ST        = 5'b00010;
  localparam logic [4:0] OP_ADD       = 5'b00011;
  localparam logic [4:0] OP_ALU_R_MAX = 5'b01011;
  localparam logic [4:0] OP_ADDI      = 5'b01100;
  localparam logic [4:0] OP_ORI       = 5'b01110;
  localparam logic [4:0] OP_MUL       = 5'b01111;
  localparam logic [4:0] OP_DIV       = 5'b10000;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  // Address calculation for LD/LDI/ST always uses the ADD operation.
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_F0    = 4'd0,
    S_F1    = 4'd1,
    S_F2    = 4'd2,
    S_DEC   = 4'd3,
    S_E3    = 4'd4,
    S_E4    = 4'd5,
    S_E5    = 4'd6,
    S_E6    = 4'd7,
    S_E7    = 4'd8,
    S_HALT  = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_ALU_R = 3'd0,
    C_ALU_I = 3'd1,
    C_LD    = 3'd2,
    C_LDI   = 3'd3,
    C_ST    = 3'd4,
    C_NOP   = 3'd5,
    C_HALT  = 3'd6,
    C_ILL   = 3'd7
  } class_t;

  function automatic class_t decode_op(input logic [4:0] op);
    class_t c;
    c = C_ILL;
    if ((op >= OP_ADD && op <= OP_ALU_R_MAX) || op == OP_MUL || op == OP_DIV) c = C_ALU_R;
    else if (op >= OP_ADDI && op <= OP_ORI) c = C_ALU_I;
    else if (op == OP_LD)   c = C_LD;
    else if (op == OP_LDI)  c = C_LDI;
    else if (op == OP_ST)   c = C_ST;
    else if (op == OP_NOP)  c = C_NOP;
    else if (op == OP_HALT) c = C_HALT;
    return c;
  endfunction

endpackage

// File: rtl/src_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for mem_rdy in a wait state
// and flags a timeout once the count has reached WAIT_LIMIT without mem_rdy.
module src_wait_timer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic active_i,
  input  logic rdy_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // mem_rdy in the limit cycle still wins; only a missing mem_rdy times out.
  assign timeout_o = active_i && !rdy_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = '0;
    if (active_i && !rdy_i && !timeout_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch, decode and
// execute of ALU, LD/LDI/ST, NOP and HALT with timed memory waits.
module src_control_unit
  import src_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        pc_out,
  output logic        pc_inc,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        mdr_rd,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic        c_out,
  output logic [4:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        run,
  output logic        fault,
  output logic        illegal,
  output logic [3:0]  state_o
);

  state_t     state_q, state_d;
  class_t     cls_q, cls_d;
  logic [4:0] op_q, op_d;
  class_t     cls_dec;
  logic       wait_active;
  logic       timeout;
  logic       unused_ir;

  assign unused_ir = ^ir[26:0];
  assign cls_dec   = decode_op(ir[31:27]);
  assign state_o   = state_q;

  assign wait_active = (state_q == S_F1)
                    || (state_q == S_E6 && cls_q == C_LD)
                    || (state_q == S_E7 && cls_q == C_ST);

  src_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .clr       (clr),
    .active_i  (wait_active),
    .rdy_i     (mem_rdy),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_F0;
      cls_q   <= C_NOP;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    op_d    = op_q;
    pc_out  = 1'b0;
    pc_inc  = 1'b0;
    ir_in   = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    mdr_out = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    mdr_rd  = 1'b0;
    gra     = 1'b0;
    grb     = 1'b0;
    grc     = 1'b0;
    r_in    = 1'b0;
    r_out   = 1'b0;
    ba_out  = 1'b0;
    c_out   = 1'b0;
    alu_op  = 5'b00000;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    run     = 1'b1;
    fault   = 1'b0;
    illegal = 1'b0;

    unique case (state_q)
      S_F0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        mem_rd = 1'b1;
        mdr_rd = 1'b1;
        mdr_in = mem_rdy;
        if (timeout)      state_d = S_FAULT;
        else if (mem_rdy) state_d = S_F2;
      end
      S_F2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        // Opcode and class are latched here so execute does not depend on ir.
        cls_d = cls_dec;
        op_d  = ir[31:27];
        unique case (cls_dec)
          C_NOP:   state_d = S_F0;
          C_HALT:  state_d = S_HALT;
          C_ILL: begin
            illegal = 1'b1;
            state_d = S_F0;
          end
          default: state_d = S_E3;
        endcase
      end
      S_E3: begin
        grb  = 1'b1;
        y_in = 1'b1;
        if (cls_q == C_ALU_R || cls_q == C_ALU_I) r_out  = 1'b1;
        else                                      ba_out = 1'b1;
        state_d = S_E4;
      end
      S_E4: begin
        z_in = 1'b1;
        if (cls_q == C_ALU_R) begin
          grc    = 1'b1;
          r_out  = 1'b1;
          alu_op = op_q;
        end else if (cls_q == C_ALU_I) begin
          c_out  = 1'b1;
          alu_op = op_q;
        end else begin
          c_out  = 1'b1;
          alu_op = ALU_ADD;
        end
        state_d = S_E5;
      end
      S_E5: begin
        zlo_out = 1'b1;
        if (cls_q == C_LD || cls_q == C_ST) begin
          mar_in  = 1'b1;
          state_d = S_E6;
        end else begin
          gra     = 1'b1;
          r_in    = 1'b1;
          state_d = S_F0;
        end
      end
      S_E6: begin
        if (cls_q == C_LD) begin
          mem_rd = 1'b1;
          mdr_rd = 1'b1;
          mdr_in = mem_rdy;
          if (timeout)      state_d = S_FAULT;
          else if (mem_rdy) state_d = S_E7;
        end else begin
          gra     = 1'b1;
          r_out   = 1'b1;
          mdr_in  = 1'b1;
          state_d = S_E7;
        end
      end
      S_E7: begin
        if (cls_q == C_LD) begin
          mdr_out = 1'b1;
          gra     = 1'b1;
          r_in    = 1'b1;
          state_d = S_F0;
        end else begin
          mem_wr = 1'b1;
          if (timeout)      state_d = S_FAULT;
          else if (mem_rdy) state_d = S_F0;
        end
      end
      S_HALT: begin
        run = 1'b0;
      end
      S_FAULT: begin
        run   = 1'b0;
        fault = 1'b1;
      end
      default: state_d = S_F0;
    endcase

    // While clr is held every strobe is forced low so no register enable or
    // memory request can leak out of the reset state.
    if (clr) begin
      pc_out  = 1'b0;
      pc_inc  = 1'b0;
      ir_in   = 1'b0;
      mar_in  = 1'b0;
      mdr_in  = 1'b0;
      mdr_out = 1'b0;
      y_in    = 1'b0;
      z_in    = 1'b0;
      zlo_out = 1'b0;
      mdr_rd  = 1'b0;
      gra     = 1'b0;
      grb     = 1'b0;
      grc     = 1'b0;
      r_in    = 1'b0;
      r_out   = 1'b0;
      ba_out  = 1'b0;
      c_out   = 1'b0;
      alu_op  = 5'b00000;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      run     = 1'b1;
      fault   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
